// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU front end: word geometry, opcode field,
// fetch FSM encoding and the {pc, instr} record carried through the prefetch buffer.
package cpu16_pkg;

  localparam int WORD_W     = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [3:0] opcode_of(input logic [WORD_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO of {pc, instr} records between fetch and decode.
// flush beats push and pop; a push into a full buffer only lands alongside a pop.
module fetch_buffer
  import cpu16_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  // When full, wr_ptr == rd_ptr: the new word reuses the slot being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, addresses the combinational instruction memory,
// queues returned words for decode and handles branch redirect and HALT stop.
module instruction_fetch_unit
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'd0,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT,
  parameter int          DEPTH       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [15:0]  fetch_pc;
  logic [15:0]  pc_next;
  logic         push;
  logic         pop;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= pc_next;
    end
  end

  // Redirect overrides everything: the buffer is flushed, nothing is pushed,
  // and any pop offered in that cycle is dropped along with the flush.
  always_comb begin
    state_next  = state;
    pc_next     = fetch_pc;
    push        = 1'b0;
    pop         = out_valid && out_ready && !redirect_valid;
    wdata.pc    = fetch_pc;
    wdata.instr = imem_data;
    if (redirect_valid) begin
      state_next = RUN;
      pc_next    = redirect_pc;
    end else begin
      case (state)
        BOOT: state_next = RUN;
        RUN: begin
          if ((count < FULL_CNT) || pop) begin
            push    = 1'b1;
            pc_next = fetch_pc + 16'd1;
            if (opcode_of(imem_data) == HALT_OPCODE) begin
              state_next = HALT;
            end
          end
        end
        HALT:    state_next = HALT;
        default: state_next = BOOT;
      endcase
    end
  end

  fetch_buffer u_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  assign imem_addr = fetch_pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign halted    = (state == HALT);

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Requester side of the instruction-memory interface. Owns the program counter and drives the word address into the combinational InstructionMemory (16-bit address in, 16-bit instruction out, same-cycle).
- Captures each returned word, with its PC, into a 2-entry prefetch buffer and hands it to decode over a valid/ready handshake.
- Handles branch redirect (flush) and HALT-opcode stop.

Parameters:
- RESET_PC, 16'd0, PC loaded on reset.
- HALT_OPCODE, 4'hF, value of instr[15:12] that stops fetching.
- DEPTH, 2, prefetch buffer entries. Fixed at 2; other values are unsupported.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  16  word address (PC) driven to InstructionMemory.
- imem_data  input  16  instruction returned combinationally for imem_addr.
- out_valid  output  1  buffer head holds a valid instruction.
- out_ready  input  1  decode accepts head this cycle.
- out_instr  output  16  head instruction.
- out_pc  output  16  PC of head instruction.
- redirect_valid  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  16  new fetch address.
- halted  output  1  fetch stopped on HALT_OPCODE.

Behaviour:
- Reset (async assert, sync deassert in use):
  - fetch_pc = RESET_PC; imem_addr = RESET_PC.
  - Buffer empty, pointers 0, count 0.
  - out_valid = 0, out_instr = 0, out_pc = 0, halted = 0.
  - state = BOOT.
- imem_addr = fetch_pc at all times (registered, no combinational path from any input).
- FSM:
  - BOOT: one idle cycle, then RUN. redirect_valid is accepted in BOOT.
  - RUN:
    - Push when count < 2, or count == 2 and a pop occurs the same cycle.
    - A push writes {fetch_pc, imem_data} and sets fetch_pc = fetch_pc + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
    - If the pushed word has imem_data[15:12] == HALT_OPCODE: go to HALT and hold fetch_pc at that word's PC + 1. The HALT word itself is delivered to decode.
  - HALT: no pushes. halted = 1. The buffer still drains normally. Exit only via redirect_valid, which goes to RUN and clears halted.
- Pop: out_valid && out_ready. Head is removed at the clock edge.
- Push and pop in the same cycle: count unchanged.
- Outputs out_valid, out_instr and out_pc come straight from the buffer head register.
- Fetch latency: a word at address A is visible on out_instr one cycle after fetch_pc == A, when the buffer is not blocked.
- Redirect (highest priority):
  - In the cycle redirect_valid = 1: buffer flushed (count = 0), no push, any pop is discarded.
  - Next cycle: fetch_pc = redirect_pc, state = RUN, halted = 0.
  - Decode must not rely on a pop in a redirect cycle.
  - Redirect on consecutive cycles: the last one wins.
- Full buffer with out_ready = 0: fetch_pc holds, imem_addr stable, no data is lost.
- Reset mid-operation: every element returns to its reset value immediately (async), including a half-drained buffer and the HALT state.

Decomposition:
- Shared package cpu16_pkg holds:
  - WORD_W = 16.
  - OPCODE_MSB = 15, OPCODE_LSB = 12.
  - HALT_OPCODE default.
  - Fetch FSM state encoding: BOOT, RUN, HALT.
- One natural sub-module: fetch_buffer, a 2-entry synchronous FIFO of 32-bit {pc, instr} entries.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - flush has priority over push and pop.
- instruction_fetch_unit instantiates fetch_buffer and owns the PC and FSM.

Test Plan:
- Sequential stream: reset, RESET_PC = 0, memory holds 0x1000 + addr, out_ready = 1. Required: out_valid first rises in cycle 3 after reset release, then delivers (pc 0, 0x1000), (1, 0x1001), (2, 0x1002) on consecutive cycles.
- Backpressure: hold out_ready = 0 for 5 cycles. Required: count saturates at 2 with head (0, 0x1000), imem_addr frozen at 2. Release out_ready: stream resumes at pc 0, 1, 2 with no gap or duplicate.
- Redirect: while streaming at pc 4, pulse redirect_valid with redirect_pc = 16'd10. Required: buffer flushed that cycle, next imem_addr = 10, next delivered pair is (10, mem[10]), and no pc 5 or 6 is ever delivered.
- Halt: mem[3] = 0xF000. Required: words at pc 0..3 delivered, halted = 1 after pc 3 is pushed, imem_addr stays 4. A later redirect_pc = 0 clears halted and restarts fetch at pc 0.
- Wrap: redirect_pc = 16'hFFFF. Required: delivered PCs are 0xFFFF, then 0x0000, then 0x0001.
- Async reset mid-run: assert rst_n = 0 between clock edges with 2 entries buffered. Required: out_valid = 0, imem_addr = RESET_PC and halted = 0 immediately, before the next clock edge.
